// File: rtl/data_generator.sv
// AXI-Stream pattern source: an incrementing 16-bit word replicated across 256 bits,
// framed into fixed-length packets with idle gaps. Optional error injection via DATA_GEN_ERR_INJECT_EN.
module data_generator #(
  parameter int unsigned PACKET_BEATS = 64,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ENABLE,
  input  logic         AXIS_TREADY,
`ifdef DATA_GEN_ERR_INJECT_EN
  input  logic         INJECT_ERROR,
  output logic [31:0]  ERRORS_INJECTED,
`endif
  output logic [31:0]  PACKETS_SENT,
  output logic [255:0] AXIS_TDATA,
  output logic         AXIS_TVALID,
  output logic         AXIS_TLAST
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  localparam logic [15:0] LAST_BEAT  = 16'(PACKET_BEATS - 1);
  localparam logic [15:0] LAST_GAP   = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);
  localparam bit          HAS_GAP    = (GAP_CYCLES != 0);
  localparam bit          SINGLE_BEAT = (PACKET_BEATS == 1);

  function automatic logic [255:0] build_beat(input logic [15:0] word, input logic corrupt);
    logic [255:0] beat;
    beat = {16{word}};
    if (corrupt) beat[255:240] = ~word;
    return beat;
  endfunction

  state_t        state_q, state_d;
  logic [15:0]   word_q, word_d;
  logic [15:0]   beat_q, beat_d;
  logic [15:0]   gap_q, gap_d;
  logic [31:0]   pkts_q, pkts_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic [255:0]  tdata_q, tdata_d;

  logic          handshake;
  logic          load;
  logic [15:0]   load_word;
  logic          load_last;
  logic          corrupt_sel;
  logic [15:0]   beat_inc;
  logic [15:0]   word_inc;

`ifdef DATA_GEN_ERR_INJECT_EN
  logic          inject_q, inject_d;
  logic          corrupt_q, corrupt_d;
  logic [31:0]   errs_q, errs_d;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    pkts_d    = pkts_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    handshake = tvalid_q & AXIS_TREADY;
    load      = 1'b0;
    load_word = word_q;
    load_last = SINGLE_BEAT;
    beat_inc  = beat_q + 16'd1;
    word_inc  = word_q + 16'd1;

    // word_q is the word on the bus while sending, and the next word to send otherwise.
    case (state_q)
      ST_IDLE: begin
        if (ENABLE) begin
          state_d = ST_SEND;
          load    = 1'b1;
        end
      end
      ST_SEND: begin
        if (handshake) begin
          word_d = word_inc;
          if (tlast_q) begin
            pkts_d   = pkts_q + 32'd1;
            beat_d   = 16'd0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            if (HAS_GAP) begin
              state_d = ST_GAP;
              gap_d   = 16'd0;
            end else if (ENABLE) begin
              load      = 1'b1;
              load_word = word_inc;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_d    = beat_inc;
            load      = 1'b1;
            load_word = word_inc;
            load_last = (beat_inc == LAST_BEAT);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == LAST_GAP) begin
          if (ENABLE) begin
            state_d = ST_SEND;
            load    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef DATA_GEN_ERR_INJECT_EN
    inject_d  = inject_q;
    corrupt_d = corrupt_q;
    errs_d    = errs_q;
    // An armed flag belongs to the beat it already corrupted until that beat is accepted.
    corrupt_sel = inject_q & ~(handshake & corrupt_q);
    if (handshake) corrupt_d = 1'b0;
    if (handshake && corrupt_q) begin
      inject_d = 1'b0;
      errs_d   = errs_q + 32'd1;
    end
    if (INJECT_ERROR && !inject_q) inject_d = 1'b1;
    if (load) corrupt_d = corrupt_sel;
`else
    corrupt_sel = 1'b0;
`endif

    if (load) begin
      tvalid_d = 1'b1;
      tlast_d  = load_last;
      tdata_d  = build_beat(load_word, corrupt_sel);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset here is synchronous and active-high.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      word_q   <= 16'd0;
      beat_q   <= 16'd0;
      gap_q    <= 16'd0;
      pkts_q   <= 32'd0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
`ifdef DATA_GEN_ERR_INJECT_EN
      inject_q  <= 1'b0;
      corrupt_q <= 1'b0;
      errs_q    <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      pkts_q   <= pkts_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
`ifdef DATA_GEN_ERR_INJECT_EN
      inject_q  <= inject_d;
      corrupt_q <= corrupt_d;
      errs_q    <= errs_d;
`endif
    end
  end

  assign PACKETS_SENT = pkts_q;
  assign AXIS_TDATA   = tdata_q;
  assign AXIS_TVALID  = tvalid_q;
  assign AXIS_TLAST   = tlast_q;
`ifdef DATA_GEN_ERR_INJECT_EN
  assign ERRORS_INJECTED = errs_q;
`endif

endmodule

// File: tb/tb_data_generator.sv
// Self-checking bench for data_generator: table-driven packet/gap/enable vectors plus
// stall, reset, wrap and (with DATA_GEN_ERR_INJECT_EN) error-injection sequences.
module tb_data_generator;

  localparam int PB  = 4;
  localparam int GAP = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         rdy = 1'b0;
  logic [31:0]  pkts;
  logic [255:0] data;
  logic         valid;
  logic         last;

  logic         rst0 = 1'b1;
  logic         en0  = 1'b0;
  logic [31:0]  pkts0;
  logic [255:0] data0;
  logic         valid0;
  logic         last0;

`ifdef DATA_GEN_ERR_INJECT_EN
  logic         inj  = 1'b0;
  logic         inj0 = 1'b0;
  logic [31:0]  errs;
  logic [31:0]  errs0;
`endif

  always #5 clk = ~clk;

  data_generator #(.PACKET_BEATS(PB), .GAP_CYCLES(GAP)) dut (
    .clock(clk), .reset(rst), .ENABLE(en), .AXIS_TREADY(rdy),
`ifdef DATA_GEN_ERR_INJECT_EN
    .INJECT_ERROR(inj), .ERRORS_INJECTED(errs),
`endif
    .PACKETS_SENT(pkts), .AXIS_TDATA(data), .AXIS_TVALID(valid), .AXIS_TLAST(last)
  );

  data_generator #(.PACKET_BEATS(1), .GAP_CYCLES(0)) dut0 (
    .clock(clk), .reset(rst0), .ENABLE(en0), .AXIS_TREADY(1'b1),
`ifdef DATA_GEN_ERR_INJECT_EN
    .INJECT_ERROR(inj0), .ERRORS_INJECTED(errs0),
`endif
    .PACKETS_SENT(pkts0), .AXIS_TDATA(data0), .AXIS_TVALID(valid0), .AXIS_TLAST(last0)
  );

  typedef struct {
    bit          en;
    bit          rdy;
    bit          v;
    bit          l;
    logic [15:0] w;
    logic [31:0] p;
  } vec_t;

  vec_t tbl [26];

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0]  exp_word;
  int           exp_idx;
  logic [31:0]  exp_pkts;
  bit           held;
  logic [255:0] held_data;
  logic         held_last;

  function automatic logic [255:0] rep(input logic [15:0] w);
    return {16{w}};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Called at a negedge: checks the current beat against the model, picks TREADY for the next edge.
  task automatic beat_step(input bit r);
    if (held) begin
      check("stall_valid", 256'(valid), 256'(1'b1));
      check("stall_data", data, held_data);
      check("stall_last", 256'(last), 256'(held_last));
    end
    check("model_pkts", 256'(pkts), 256'(exp_pkts));
    rdy  = r;
    held = 1'b0;
    if (valid) begin
      if (r) begin
        check("accept_data", data, rep(exp_word));
        check("accept_last", 256'(last), 256'(exp_idx == PB - 1));
        exp_word = exp_word + 16'd1;
        if (exp_idx == PB - 1) begin
          exp_idx  = 0;
          exp_pkts = exp_pkts + 32'd1;
        end else begin
          exp_idx++;
        end
      end else begin
        held      = 1'b1;
        held_data = data;
        held_last = last;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int          bad_vl;
    int          bad_d;
    int          bad_p;
    bit          found;

    tbl[0]  = '{1, 1, 1, 0, 16'h0000, 0};
    tbl[1]  = '{1, 1, 1, 0, 16'h0001, 0};
    tbl[2]  = '{1, 1, 1, 0, 16'h0002, 0};
    tbl[3]  = '{1, 1, 1, 1, 16'h0003, 0};
    tbl[4]  = '{1, 1, 0, 0, 16'h0000, 1};
    tbl[5]  = '{1, 1, 0, 0, 16'h0000, 1};
    tbl[6]  = '{1, 1, 1, 0, 16'h0004, 1};
    tbl[7]  = '{1, 1, 1, 0, 16'h0005, 1};
    tbl[8]  = '{1, 0, 1, 0, 16'h0005, 1};
    tbl[9]  = '{1, 0, 1, 0, 16'h0005, 1};
    tbl[10] = '{1, 1, 1, 0, 16'h0006, 1};
    tbl[11] = '{1, 1, 1, 1, 16'h0007, 1};
    tbl[12] = '{1, 0, 1, 1, 16'h0007, 1};
    tbl[13] = '{0, 1, 0, 0, 16'h0000, 2};
    tbl[14] = '{0, 1, 0, 0, 16'h0000, 2};
    tbl[15] = '{0, 1, 0, 0, 16'h0000, 2};
    tbl[16] = '{0, 1, 0, 0, 16'h0000, 2};
    tbl[17] = '{1, 1, 1, 0, 16'h0008, 2};
    tbl[18] = '{0, 1, 1, 0, 16'h0009, 2};
    tbl[19] = '{0, 1, 1, 0, 16'h000A, 2};
    tbl[20] = '{0, 1, 1, 1, 16'h000B, 2};
    tbl[21] = '{0, 1, 0, 0, 16'h0000, 3};
    tbl[22] = '{0, 1, 0, 0, 16'h0000, 3};
    tbl[23] = '{0, 1, 0, 0, 16'h0000, 3};
    tbl[24] = '{0, 1, 0, 0, 16'h0000, 3};
    tbl[25] = '{0, 1, 0, 0, 16'h0000, 3};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 256'(valid), 256'(1'b0));
    check("rst_last", 256'(last), 256'(1'b0));
    check("rst_data", data, 256'd0);
    check("rst_pkts", 256'(pkts), 256'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_valid", 256'(valid), 256'(1'b0));

    // Packets, gap, stalls, enable at boundaries
    for (int i = 0; i < 26; i++) begin
      en  = tbl[i].en;
      rdy = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 256'(valid), 256'(tbl[i].v));
      if (tbl[i].v) begin
        check($sformatf("vec%0d_last", i), 256'(last), 256'(tbl[i].l));
        check($sformatf("vec%0d_data", i), data, rep(tbl[i].w));
      end
      check($sformatf("vec%0d_pkts", i), 256'(pkts), 256'(tbl[i].p));
    end

    // Random back-pressure
    exp_word = 16'h000C;
    exp_idx  = 0;
    exp_pkts = 32'd3;
    held     = 1'b0;
    en       = 1'b1;
    for (int i = 0; i < 300; i++) beat_step(1'($urandom_range(0, 1)));

    // Reset while beat index 2 is on the bus
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid && exp_idx == 2) begin
        found = 1'b1;
        break;
      end
      beat_step(1'b1);
    end
    check("reset_wait_idx2", 256'(found), 256'(1'b1));
    rst = 1'b1;
    rdy = 1'b1;
    @(negedge clk);
    check("midrst_valid", 256'(valid), 256'(1'b0));
    check("midrst_data", data, 256'd0);
    check("midrst_pkts", 256'(pkts), 256'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 256'(valid), 256'(1'b1));
    check("post_rst_data", data, rep(16'h0000));
    check("post_rst_pkts", 256'(pkts), 256'd0);
    exp_word = 16'h0000;
    exp_idx  = 0;
    exp_pkts = 32'd0;
    held     = 1'b0;
    for (int i = 0; i < 8; i++) beat_step(1'b1);

`ifdef DATA_GEN_ERR_INJECT_EN
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (valid && exp_word == 16'h0010) begin
        found = 1'b1;
        break;
      end
      beat_step(1'b1);
    end
    check("inj_wait_0x10", 256'(found), 256'(1'b1));
    rdy = 1'b0;
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    check("inj_stalled_clean", data, rep(16'h0010));
    check("inj_errs_0", 256'(errs), 256'd0);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    check("inj_stalled_clean2", data, rep(16'h0010));
    rdy = 1'b1;
    @(negedge clk);
    check("inj_corrupt_beat", data, {16'hFFEE, {15{16'h0011}}});
    check("inj_errs_pending", 256'(errs), 256'd0);
    @(negedge clk);
    check("inj_after_clean", data, rep(16'h0012));
    check("inj_errs_1", 256'(errs), 256'd1);
    repeat (6) @(negedge clk);
    check("inj_errs_stays_1", 256'(errs), 256'd1);
`endif

    // Back-to-back single-beat packets through the 16-bit word wrap
    en0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    bad_vl = 0;
    bad_d  = 0;
    bad_p  = 0;
    for (int i = 0; i < 65537; i++) begin
      @(negedge clk);
      if (!valid0 || !last0) bad_vl++;
      if (data0 !== rep(i[15:0])) bad_d++;
      if (pkts0 !== 32'(i)) bad_p++;
      if (i == 65535) check("wrap_ffff", data0, rep(16'hFFFF));
      if (i == 65536) begin
        check("wrap_0000", data0, rep(16'h0000));
        check("wrap_pkts", 256'(pkts0), 256'd65536);
      end
    end
    check("b2b_valid_last_errors", 256'(bad_vl), 256'd0);
    check("b2b_data_errors", 256'(bad_d), 256'd0);
    check("b2b_pkts_errors", 256'(bad_p), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
